// File: rtl/fetch_controller_pkg.sv
// ----------------------------------------------------------------------------
// fetch_controller_pkg
// Shared definitions for the instruction fetch controller: the controller
// state encoding, the size of one instruction in bytes, and the instruction
// word that stops fetching.
// ----------------------------------------------------------------------------
package fetch_controller_pkg;

    // Controller states: waiting for start, fetching, stopped.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Every instruction occupies one 32-bit word.
    localparam int INSN_BYTES = 4;

    // An all-zero instruction word marks the end of the program.
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_controller.sv
// ----------------------------------------------------------------------------
// fetch_controller
// Walks a combinational instruction memory one word at a time and presents
// each instruction to decode through a valid/ready output stage. Fetching
// starts on a start pulse, stops on an all-zero word or when the pc leaves
// the memory, and resumes from a redirect target.
//
// Ports
//   clk, reset      : clock and synchronous active-high reset
//   start           : one-cycle pulse, leaves IDLE
//   imem_addr       : byte address into instruction memory (the pc register)
//   imem_data       : instruction word at imem_addr, same cycle
//   inst_out/pc_out : registered instruction and its byte address
//   inst_valid      : inst_out/pc_out hold an instruction
//   inst_ready      : decode takes inst_out this cycle
//   redirect_valid  : branch/jump redirect request, redirect_pc its target
//   halted          : high while fetching is stopped
// ----------------------------------------------------------------------------
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam logic [31:0] PC_LIMIT  = 32'(IMEM_WORDS * INSN_BYTES);
    localparam logic [31:0] PC_STEP   = 32'(INSN_BYTES);
    localparam logic [31:0] ALIGN_MSK = ~32'h0000_0003;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         valid_q, valid_d;
    logic         out_free;
    logic         stop_here;

    // The output stage can take a new instruction when it is empty or its
    // current one leaves this cycle. Fetching stops either when the pc has
    // run past the memory or when the word at the pc is the halt word; the
    // range test comes first so data beyond the memory is never trusted.
    always_comb begin
        out_free  = !valid_q || inst_ready;
        stop_here = (pc_q >= PC_LIMIT) || (imem_data == HALT_WORD);
    end

    // Next-state and next-register logic. A redirect beats everything else
    // and flushes the output stage, even a stalled instruction. When fetching
    // stops, an instruction already presented stays until decode takes it.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc & ALIGN_MSK;
                end else if (stop_here) begin
                    state_d = HALT;
                    valid_d = valid_q && !inst_ready;
                end else if (out_free) begin
                    inst_d   = imem_data;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + PC_STEP;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    state_d = FETCH;
                    valid_d = 1'b0;
                    pc_d    = redirect_pc & ALIGN_MSK;
                end else begin
                    valid_d = valid_q && !inst_ready;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any stalled instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC & ALIGN_MSK;
            inst_q   <= 32'h0;
            pc_out_q <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_addr  = pc_q;
    assign inst_out   = inst_q;
    assign pc_out     = pc_out_q;
    assign inst_valid = valid_q;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// ----------------------------------------------------------------------------
// tb_fetch_controller
// Bench for fetch_controller: a directed vector table over a three-word
// program, a hand-written run against a two-word memory, and a randomized
// run compared against a behavioural model of the fetch rules.
// ----------------------------------------------------------------------------
module tb_fetch_controller;

    localparam logic [31:0] W0 = 32'h0198_06B3;
    localparam logic [31:0] W1 = 32'h4034_02B3;
    localparam logic [31:0] W2 = 32'h0031_70B3;

    logic        clk = 1'b0;
    logic        reset, start, inst_ready, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_data, inst_out, pc_out;
    logic        inst_valid, halted;

    logic        reset2, start2, inst_ready2;
    logic [31:0] imem_addr2, imem_data2, inst_out2, pc_out2;
    logic        inst_valid2, halted2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Program memory: three instructions followed by zero words.
    function automatic logic [31:0] main_mem(input logic [31:0] addr);
        case (addr[31:2])
            30'd0:   return W0;
            30'd1:   return W1;
            30'd2:   return W2;
            default: return 32'h0;
        endcase
    endfunction

    assign imem_data  = main_mem(imem_addr);
    // Every address returns a nonzero word, so only the range limit stops it.
    assign imem_data2 = 32'h1000_0001 + imem_addr2;

    fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(64)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halted(halted)
    );

    fetch_controller #(.RESET_PC(32'h0), .IMEM_WORDS(2)) dut2 (
        .clk(clk), .reset(reset2), .start(start2),
        .imem_addr(imem_addr2), .imem_data(imem_data2),
        .inst_out(inst_out2), .pc_out(pc_out2), .inst_valid(inst_valid2),
        .inst_ready(inst_ready2), .redirect_valid(1'b0),
        .redirect_pc(32'h0), .halted(halted2)
    );

    typedef struct {
        logic        rst;
        logic        st;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        eh;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs[22];

    // Behavioural model: running/stopped flags, pc and the presented slot.
    bit          m_running, m_stopped, m_valid;
    logic [31:0] m_pc, m_pc_out, m_inst;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset          = v.rst;
        start          = v.st;
        inst_ready     = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        compare($sformatf("row%0d inst_valid", idx), {31'h0, inst_valid}, {31'h0, v.ev});
        compare($sformatf("row%0d pc_out", idx), pc_out, v.epc);
        compare($sformatf("row%0d inst_out", idx), inst_out, v.einst);
        compare($sformatf("row%0d halted", idx), {31'h0, halted}, {31'h0, v.eh});
        compare($sformatf("row%0d imem_addr", idx), imem_addr, v.eaddr);
    endtask

    // One clock of the fetch rules, evaluated on the inputs just driven.
    task automatic model_step();
        logic [31:0] word;
        if (reset) begin
            m_running = 0; m_stopped = 0; m_valid = 0;
            m_pc = 32'h0; m_pc_out = 32'h0; m_inst = 32'h0;
        end else if (!m_running && !m_stopped) begin
            if (start) m_running = 1;
        end else if (redirect_valid) begin
            m_valid = 0;
            m_pc = {redirect_pc[31:2], 2'b00};
            m_running = 1; m_stopped = 0;
        end else if (m_stopped) begin
            if (inst_ready) m_valid = 0;
        end else begin
            word = main_mem(m_pc);
            if (m_pc >= 32'd256 || word == 32'h0) begin
                m_running = 0; m_stopped = 1;
                if (inst_ready) m_valid = 0;
            end else if (!m_valid || inst_ready) begin
                m_pc_out = m_pc;
                m_inst = word;
                m_valid = 1;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic [31:0] got_pc[$];
        logic [31:0] got_inst[$];
        bit          addr_ok;

        //             rst st rdy rv rpc      ev epc     einst  eh eaddr
        vecs[0]  = '{1, 0, 0, 0, 32'h0,  0, 32'h0, 32'h0, 0, 32'h0};
        vecs[1]  = '{0, 1, 0, 0, 32'h0,  0, 32'h0, 32'h0, 0, 32'h0};
        vecs[2]  = '{0, 0, 1, 0, 32'h0,  1, 32'h0, W0,    0, 32'h4};
        vecs[3]  = '{0, 0, 1, 0, 32'h0,  1, 32'h4, W1,    0, 32'h8};
        vecs[4]  = '{0, 0, 1, 0, 32'h0,  1, 32'h8, W2,    0, 32'hC};
        vecs[5]  = '{0, 0, 1, 0, 32'h0,  0, 32'h8, W2,    1, 32'hC};
        vecs[6]  = '{0, 0, 1, 0, 32'h0,  0, 32'h8, W2,    1, 32'hC};
        vecs[7]  = '{0, 0, 0, 1, 32'h6,  0, 32'h8, W2,    0, 32'h4};
        vecs[8]  = '{0, 0, 1, 0, 32'h0,  1, 32'h4, W1,    0, 32'h8};
        vecs[9]  = '{0, 0, 0, 0, 32'h0,  1, 32'h4, W1,    0, 32'h8};
        vecs[10] = '{0, 0, 0, 0, 32'h0,  1, 32'h4, W1,    0, 32'h8};
        vecs[11] = '{0, 0, 0, 0, 32'h0,  1, 32'h4, W1,    0, 32'h8};
        vecs[12] = '{0, 0, 1, 0, 32'h0,  1, 32'h8, W2,    0, 32'hC};
        vecs[13] = '{0, 0, 0, 0, 32'h0,  1, 32'h8, W2,    1, 32'hC};
        vecs[14] = '{0, 0, 0, 1, 32'h0,  0, 32'h8, W2,    0, 32'h0};
        vecs[15] = '{0, 0, 1, 0, 32'h0,  1, 32'h0, W0,    0, 32'h4};
        vecs[16] = '{0, 0, 0, 0, 32'h0,  1, 32'h0, W0,    0, 32'h4};
        vecs[17] = '{1, 0, 0, 0, 32'h0,  0, 32'h0, 32'h0, 0, 32'h0};
        vecs[18] = '{0, 0, 1, 1, 32'h40, 0, 32'h0, 32'h0, 0, 32'h0};
        vecs[19] = '{0, 1, 1, 0, 32'h0,  0, 32'h0, 32'h0, 0, 32'h0};
        vecs[20] = '{0, 0, 1, 0, 32'h0,  1, 32'h0, W0,    0, 32'h4};
        vecs[21] = '{0, 1, 1, 0, 32'h0,  1, 32'h4, W1,    0, 32'h8};

        reset = 1; start = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
        reset2 = 1; start2 = 0; inst_ready2 = 0;
        @(posedge clk); #1;

        // Directed table on the three-word program.
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk); #1;
            checkOutput(vecs[i], i);
        end

        // Two-word memory: delivers 0x0 and 0x4, then stops at 0x8.
        reset2 = 1; @(posedge clk); #1;
        reset2 = 0; start2 = 1; inst_ready2 = 1;
        @(posedge clk); #1;
        start2 = 0;
        addr_ok = 1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (imem_addr2 > 32'h8) addr_ok = 0;
            if (inst_valid2) begin
                got_pc.push_back(pc_out2);
                got_inst.push_back(inst_out2);
            end
        end
        compare("range addr_bound", {31'h0, addr_ok}, 32'h1);
        compare("range count", got_pc.size(), 32'd2);
        if (got_pc.size() >= 2) begin
            compare("range pc0", got_pc[0], 32'h0);
            compare("range inst0", got_inst[0], 32'h1000_0001);
            compare("range pc1", got_pc[1], 32'h4);
            compare("range inst1", got_inst[1], 32'h1000_0005);
        end
        compare("range halted", {31'h0, halted2}, 32'h1);
        compare("range final_addr", imem_addr2, 32'h8);
        reset2 = 1;

        // Randomized run against the behavioural model.
        reset = 1; start = 0; redirect_valid = 0; inst_ready = 0;
        model_step();
        @(posedge clk); #1;
        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 99) == 0);
            start          = ($urandom_range(0, 7) == 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 32'($urandom_range(0, 32'h1F));
            model_step();
            @(posedge clk); #1;
            compare($sformatf("rand%0d inst_valid", n), {31'h0, inst_valid}, {31'h0, m_valid});
            compare($sformatf("rand%0d halted", n), {31'h0, halted}, {31'h0, m_stopped});
            compare($sformatf("rand%0d imem_addr", n), imem_addr, m_pc);
            compare($sformatf("rand%0d pc_out", n), pc_out, m_pc_out);
            compare($sformatf("rand%0d inst_out", n), inst_out, m_inst);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IMEM_WORDS, default 64, instruction memory depth in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; leaves IDLE and begins fetching.
REQ-006 imem_addr  output  32  byte address to the combinational instruction memory; equals the pc register.
REQ-007 imem_data  input  32  instruction word returned combinationally for imem_addr in the same cycle.
REQ-008 inst_out  output  32  registered instruction presented to decode.
REQ-009 pc_out  output  32  byte address of inst_out.
REQ-010 inst_valid  output  1  inst_out/pc_out hold a valid instruction.
REQ-011 inst_ready  input  1  decode accepts inst_out this cycle.
REQ-012 redirect_valid  input  1  branch/jump redirect request.
REQ-013 redirect_pc  input  32  redirect target byte address.
REQ-014 halted  output  1  high while in HALT.

Function
REQ-015 States: IDLE, FETCH, HALT; IDLE->FETCH on start; FETCH->HALT on halt condition; HALT->FETCH on redirect_valid; IDLE ignores redirect_valid.
REQ-016 Handshake: transfer when inst_valid && inst_ready; while inst_valid && !inst_ready, inst_out, pc_out, inst_valid and pc are held stable.
REQ-017 Capture: in FETCH, when output stage empty or transferring, with no redirect, imem_data/pc load into inst_out/pc_out, inst_valid=1, pc+=4.
REQ-018 Latency: start in cycle N -> inst_valid=1 with pc_out=RESET_PC in cycle N+2; then one instruction per cycle with inst_ready held high.
REQ-019 Redirect (FETCH or HALT): inst_valid=0 next cycle (flush, including a stalled instruction); pc=redirect_pc with bits[1:0] forced to 0; state=FETCH; capture resumes the following cycle.
REQ-020 Redirect has priority over capture, stall and halt in the same cycle.
REQ-021 Halt on zero word: capturing imem_data==32'h0 enters HALT; zero word never presented; inst_valid=0; pc unchanged.
REQ-022 Halt on range: pc >= IMEM_WORDS*4 at capture time enters HALT with no capture; no address wrap-around.
REQ-023 A valid instruction stalled at HALT entry stays presented until transferred.
REQ-024 start while in FETCH or HALT is ignored.
REQ-025 pc arithmetic is 32-bit unsigned; imem_addr always word-aligned.

Reset
REQ-026 reset=1 at a rising edge: state=IDLE, pc=RESET_PC, inst_out=0, pc_out=0, inst_valid=0, halted=0.
REQ-027 reset overrides start, redirect and any stalled instruction mid-operation; the stalled instruction is discarded.
REQ-028 Outputs stay at reset values until the first start after reset deasserts.

Structure
REQ-029 Shared package holds the state enum (IDLE/FETCH/HALT), INSN_BYTES=4 and the halt word constant 32'h0.
REQ-030 No sub-module; the parent instantiates the instruction memory and connects imem_addr/imem_data.

Verification
Bench memory: words 0..2 = 0x019806B3, 0x403402B3, 0x003170B3; remaining words = 0.
REQ-031 Reset, start pulse, inst_ready=1 -> pc_out 0x0, 0x4, 0x8 with inst_out as loaded on consecutive cycles; then halted=1, pc_out stays 0x8, 0x0 never valid.
REQ-032 inst_ready=0 for 3 cycles while pc_out=0x4 -> inst_out=0x403402B3 held stable; transfer on release; next pc_out=0x8.
REQ-033 redirect_valid with redirect_pc=0x0 and pc_out=0x8 stalled -> inst_valid=0 next cycle; then pc_out=0x0 with inst_out=0x019806B3.
REQ-034 In HALT, redirect_pc=0x6 -> pc=0x4; next valid instruction is pc_out=0x4, inst_out=0x403402B3; halted=0.
REQ-035 IMEM_WORDS=2, all words nonzero -> pc_out 0x0, 0x4 delivered; HALT at pc=0x8; imem_addr never exceeds 0x8.
REQ-036 reset asserted with inst_valid=1 and inst_ready=0 -> next cycle inst_valid=0, pc_out=0, state IDLE; start required to resume from RESET_PC.
